// File: rtl/mmio_timer_pwm_pkg.sv
// mmio_timer_pwm_pkg: register map, bit indices and store-size helpers
// shared by the timer/PWM block and its PWM channel slices.
package mmio_timer_pwm_pkg;

    // Byte offsets inside the 64-byte register window
    localparam logic [5:0] OFF_CTRL   = 6'h00;
    localparam logic [5:0] OFF_STATUS = 6'h04;
    localparam logic [5:0] OFF_MICROS = 6'h08;
    localparam logic [5:0] OFF_MILLIS = 6'h0C;
    localparam logic [5:0] OFF_CMP    = 6'h10;
    localparam logic [5:0] OFF_DUTY0  = 6'h20;

    // CTRL / STATUS bit positions
    localparam int CTRL_PWM_EN = 0;
    localparam int CTRL_CMP_IE = 1;
    localparam int STAT_MATCH  = 0;

    // funct3 size decode: bit1 wins over bit0
    localparam int F3_WORD_BIT = 1;
    localparam int F3_HALF_BIT = 0;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    function automatic size_e decode_size(input logic [2:0] f3);
        if (f3[F3_WORD_BIT])      return SZ_WORD;
        else if (f3[F3_HALF_BIT]) return SZ_HALF;
        else                      return SZ_BYTE;
    endfunction

    function automatic logic [3:0] lane_mask(input size_e sz,
                                             input logic [1:0] a);
        case (sz)
            SZ_WORD: return 4'hF;
            SZ_HALF: return a[1] ? 4'hC : 4'h3;
            default: return 4'b0001 << a;
        endcase
    endfunction

    // Sub-word data is replicated across lanes; the lane mask picks it.
    function automatic logic [31:0] align_data(input size_e sz,
                                               input logic [31:0] d);
        case (sz)
            SZ_WORD: return d;
            SZ_HALF: return {2{d[15:0]}};
            default: return {4{d[7:0]}};
        endcase
    endfunction

    function automatic logic [31:0] expand_mask(input logic [3:0] l);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{l[b]}};
        return m;
    endfunction

    function automatic logic [31:0] merge32(input logic [31:0] old,
                                            input logic [31:0] val,
                                            input logic [31:0] mask);
        return (old & ~mask) | (val & mask);
    endfunction

endpackage

// File: rtl/mmio_timer_pwm_if.sv
// mmio_timer_pwm_if: store/load bus into the timer/PWM window.
// wren/address/funct3/wdata from master, registered rdata from slave.
interface mmio_timer_pwm_if;
    logic        wren;
    logic [31:0] address;
    logic [2:0]  funct3;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output wren, address, funct3, wdata,
        input  rdata
    );

    modport slave (
        input  wren, address, funct3, wdata,
        output rdata
    );
endinterface

// File: rtl/mmio_timer_pwm_pwm.sv
// pwm_channel: one duty slice -- shadow duty, active duty, compare.
// Ports: clk, reset_n, en_i, wrap_i, cnt_i, we_i/wmask_i/wdata_i, shadow_o, pwm_o.
module pwm_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en_i,
    input  logic                wrap_i,
    input  logic [PWM_BITS-1:0] cnt_i,
    input  logic                we_i,
    input  logic [PWM_BITS-1:0] wmask_i,
    input  logic [PWM_BITS-1:0] wdata_i,
    output logic [PWM_BITS-1:0] shadow_o,
    output logic                pwm_o
);
    logic [PWM_BITS-1:0] shadow_q, shadow_d;
    logic [PWM_BITS-1:0] active_q;

    always_comb begin
        shadow_d = shadow_q;
        if (we_i) shadow_d = (shadow_q & ~wmask_i) | (wdata_i & wmask_i);
    end

    // Active duty only changes at a period boundary so a mid-period
    // write never produces a truncated or stretched pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            if (!en_i || wrap_i) active_q <= shadow_q;
        end
    end

    assign shadow_o = shadow_q;
    assign pwm_o    = en_i && (cnt_i < active_q);
endmodule

// File: rtl/mmio_timer_pwm.sv
// mmio_timer_pwm: MMIO microsecond/millisecond timer, compare irq, PWM.
// Ports: clk, reset_n, bus (slave), pwm_out[NUM_PWM], irq.
module mmio_timer_pwm
    import mmio_timer_pwm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FFC0,
    parameter int          CLK_FREQ  = 12000000,
    parameter int          NUM_PWM   = 4,
    parameter int          PWM_BITS  = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    mmio_timer_pwm_if.slave    bus,
    output logic [NUM_PWM-1:0] pwm_out,
    output logic               irq
);
    localparam logic [31:0] US_LAST = 32'(CLK_FREQ / 1000000 - 1);
    localparam logic [31:0] MS_LAST = 32'(CLK_FREQ / 1000 - 1);

    logic        in_win, we;
    logic [3:0]  widx;
    size_e       sz;
    logic [31:0] wmask, wval;
    logic        wr_ctrl, wr_status, wr_cmp, we_duty, clr;

    logic [31:0] us_cnt_q, ms_cnt_q;
    logic [31:0] micros_q, millis_q, cmp_q, cmp_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [31:0] ctrl_w;
    logic        status_q, status_d, match_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic        us_tick, ms_tick, pwm_wrap;
    logic [31:0] rdata_q, rdata_d;
    logic [PWM_BITS-1:0] shadow [NUM_PWM];

    assign in_win = bus.address[31:6] == BASE_ADDR[31:6];
    assign widx   = bus.address[5:2];
    assign sz     = decode_size(bus.funct3);
    assign wmask  = expand_mask(lane_mask(sz, bus.address[1:0]));
    assign wval   = align_data(sz, bus.wdata);
    assign we     = bus.wren && in_win;

    assign wr_ctrl   = we && (widx == OFF_CTRL[5:2]);
    assign wr_status = we && (widx == OFF_STATUS[5:2]);
    assign wr_cmp    = we && (widx == OFF_CMP[5:2]);
    assign we_duty   = we && widx[3];
    assign clr       = wr_status && wmask[0] && wval[STAT_MATCH];

    assign us_tick  = us_cnt_q == US_LAST;
    assign ms_tick  = ms_cnt_q == MS_LAST;
    assign pwm_wrap = ctrl_q[CTRL_PWM_EN] && (pwm_cnt_q == '1);

    assign ctrl_w = merge32({30'b0, ctrl_q}, wval, wmask);

    always_comb begin
        ctrl_d   = ctrl_q;
        cmp_d    = cmp_q;
        status_d = status_q;
        if (wr_ctrl) ctrl_d = ctrl_w[1:0];
        if (wr_cmp)  cmp_d  = merge32(cmp_q, wval, wmask);
        // A match landing on the same edge as a clear must not be lost
        if (match_q)  status_d = 1'b1;
        else if (clr) status_d = 1'b0;
    end

    always_comb begin
        rdata_d = '0;
        if (in_win) begin
            if (widx[3]) begin
                for (int i = 0; i < NUM_PWM; i++)
                    if (widx[2:0] == 3'(i)) rdata_d = 32'(shadow[i]);
            end else begin
                case (widx)
                    OFF_CTRL[5:2]:   rdata_d = {30'b0, ctrl_q};
                    OFF_STATUS[5:2]: rdata_d = {31'b0, status_q};
                    OFF_MICROS[5:2]: rdata_d = micros_q;
                    OFF_MILLIS[5:2]: rdata_d = millis_q;
                    OFF_CMP[5:2]:    rdata_d = cmp_q;
                    default:         rdata_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            us_cnt_q  <= '0;
            ms_cnt_q  <= '0;
            micros_q  <= '0;
            millis_q  <= '0;
            cmp_q     <= '0;
            ctrl_q    <= '0;
            status_q  <= 1'b0;
            match_q   <= 1'b0;
            pwm_cnt_q <= '0;
            rdata_q   <= '0;
        end else begin
            us_cnt_q <= us_tick ? '0 : us_cnt_q + 32'd1;
            ms_cnt_q <= ms_tick ? '0 : ms_cnt_q + 32'd1;
            if (us_tick) micros_q <= micros_q + 32'd1;
            if (ms_tick) millis_q <= millis_q + 32'd1;
            // Match is judged on the value MICROS is about to take and
            // lands in STATUS one cycle after MICROS shows it.
            match_q  <= us_tick && ctrl_q[CTRL_CMP_IE]
                        && (micros_q + 32'd1 == cmp_q);
            status_q <= status_d;
            ctrl_q   <= ctrl_d;
            cmp_q    <= cmp_d;
            pwm_cnt_q <= ctrl_q[CTRL_PWM_EN] ? pwm_cnt_q + 1'b1 : '0;
            rdata_q  <= rdata_d;
        end
    end

    for (genvar g = 0; g < NUM_PWM; g++) begin : g_ch
        pwm_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .en_i     (ctrl_q[CTRL_PWM_EN]),
            .wrap_i   (pwm_wrap),
            .cnt_i    (pwm_cnt_q),
            .we_i     (we_duty && (widx[2:0] == 3'(g))),
            .wmask_i  (wmask[PWM_BITS-1:0]),
            .wdata_i  (wval[PWM_BITS-1:0]),
            .shadow_o (shadow[g]),
            .pwm_o    (pwm_out[g])
        );
    end

    assign bus.rdata = rdata_q;
    assign irq       = status_q && ctrl_q[CTRL_CMP_IE];
endmodule
